// File: rtl/mem_fifo_loader.sv
// Loads the B row and ROWS A rows from mem_wrapper; B is latched as a vector and
// each A row is serialised LSB byte first into its FIFO lane (lane = row-1).
module mem_fifo_loader #(
   parameter int          ROWS       = 8,
   parameter int          BYTES      = 8,
   parameter int          DATA_WIDTH = 8,
   parameter logic [31:0] BASE_ADDR  = 32'd0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   output logic [31:0]             mem_address,
   output logic                    mem_read,
   input  logic [8*BYTES-1:0]      mem_readdata,
   input  logic                    mem_readdatavalid,
   input  logic                    mem_waitrequest,
   output logic [ROWS-1:0]         fifo_wren,
   output logic [DATA_WIDTH-1:0]   fifo_wdata,
   input  logic [ROWS-1:0]         fifo_full,
   output logic [8*BYTES-1:0]      b_vec,
   output logic                    b_valid,
   output logic                    busy,
   output logic                    done
);

   localparam int          ROW_BITS  = 8 * BYTES;
   localparam int          ROW_W     = $clog2(ROWS + 1);
   localparam int          LANE_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int          BYTE_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [32:0] LAST_ADDR = {1'b0, BASE_ADDR} + 33'(ROWS);

   generate
      if (LAST_ADDR[32]) begin : g_addr_wrap_check
         $error("mem_fifo_loader: BASE_ADDR+ROWS wraps the 32-bit address space");
      end
      if (DATA_WIDTH * BYTES > ROW_BITS) begin : g_byte_width_check
         $error("mem_fifo_loader: DATA_WIDTH*BYTES exceeds the memory row width");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAITD,
      S_PUSH,
      S_DONE
   } state_t;

   state_t                  r_state,   w_state_next;
   logic [ROW_W-1:0]        r_row,     w_row_next;
   logic [BYTE_W-1:0]       r_byte,    w_byte_next;
   logic [ROW_BITS-1:0]     r_buf,     w_buf_next;
   logic [ROW_BITS-1:0]     r_b_vec,   w_b_vec_next;
   logic                    r_b_valid, w_b_valid_next;
   logic                    r_busy,    w_busy_next;
   logic                    r_done,    w_done_next;
   logic [ROWS-1:0]         r_wren,    w_wren_next;
   logic [DATA_WIDTH-1:0]   r_wdata,   w_wdata_next;

   logic [LANE_W-1:0]       w_lane;
   logic [ROWS-1:0]         w_lane_onehot;
   logic [DATA_WIDTH-1:0]   w_bytes [BYTES];
   logic                    w_last_byte;
   logic                    w_last_row;

   // Byte k of the captured row sits at bits DATA_WIDTH*k upward.
   genvar gi;
   generate
      for (gi = 0; gi < BYTES; gi++) begin : g_bytes
         assign w_bytes[gi] = r_buf[DATA_WIDTH*gi +: DATA_WIDTH];
      end
   endgenerate

   assign w_lane        = LANE_W'(r_row - ROW_W'(1));
   assign w_lane_onehot = ROWS'(1) << w_lane;
   assign w_last_byte   = (r_byte == BYTE_W'(BYTES - 1));
   assign w_last_row    = (r_row == ROW_W'(ROWS));

   always_comb begin
      w_state_next   = r_state;
      w_row_next     = r_row;
      w_byte_next    = r_byte;
      w_buf_next     = r_buf;
      w_b_vec_next   = r_b_vec;
      w_b_valid_next = r_b_valid;
      w_busy_next    = r_busy;
      w_done_next    = r_done;
      w_wren_next    = '0;
      w_wdata_next   = r_wdata;

      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_state_next   = S_REQ;
               w_row_next     = '0;
               w_busy_next    = 1'b1;
               w_done_next    = 1'b0;
               w_b_valid_next = 1'b0;
            end
         end
         S_REQ: begin
            if (!mem_waitrequest) begin
               w_state_next = S_WAITD;
            end
         end
         S_WAITD: begin
            if (mem_readdatavalid) begin
               if (r_row == '0) begin
                  w_b_vec_next   = mem_readdata;
                  w_b_valid_next = 1'b1;
                  w_row_next     = ROW_W'(1);
                  w_state_next   = S_REQ;
               end else begin
                  w_buf_next   = mem_readdata;
                  w_byte_next  = '0;
                  w_state_next = S_PUSH;
               end
            end
         end
         S_PUSH: begin
            // A full lane stalls in place: the byte index only advances on a push.
            if (!fifo_full[w_lane]) begin
               w_wren_next  = w_lane_onehot;
               w_wdata_next = w_bytes[r_byte];
               if (w_last_byte) begin
                  if (w_last_row) begin
                     w_state_next = S_DONE;
                     w_done_next  = 1'b1;
                     w_busy_next  = 1'b0;
                  end else begin
                     w_row_next   = r_row + ROW_W'(1);
                     w_state_next = S_REQ;
                  end
               end else begin
                  w_byte_next = r_byte + BYTE_W'(1);
               end
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_row     <= '0;
         r_byte    <= '0;
         r_buf     <= '0;
         r_b_vec   <= '0;
         r_b_valid <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_wren    <= '0;
         r_wdata   <= '0;
      end else begin
         r_state   <= w_state_next;
         r_row     <= w_row_next;
         r_byte    <= w_byte_next;
         r_buf     <= w_buf_next;
         r_b_vec   <= w_b_vec_next;
         r_b_valid <= w_b_valid_next;
         r_busy    <= w_busy_next;
         r_done    <= w_done_next;
         r_wren    <= w_wren_next;
         r_wdata   <= w_wdata_next;
      end
   end

   // Request and address are decoded from state so they stay put under waitrequest.
   assign mem_read    = (r_state == S_REQ);
   assign mem_address = mem_read ? (BASE_ADDR + 32'(r_row)) : 32'd0;
   assign fifo_wren   = r_wren;
   assign fifo_wdata  = r_wdata;
   assign b_vec       = r_b_vec;
   assign b_valid     = r_b_valid;
   assign busy        = r_busy;
   assign done        = r_done;

endmodule
